// File: rtl/serial_adder32_pkg.sv
// Shared types and constants for the nibble-serial 32-bit adder.
package serial_adder32_pkg;
  localparam int WIDTH_D = 32;
  localparam int NIBBLES = WIDTH_D / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_adder32_adder4.sv
// 4-bit carry-lookahead slice; C3 is the carry into bit 3
// so the caller can derive signed overflow.
module Adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic [3:0] S,
  output logic       C4,
  output logic       C3
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g    = A & B;
  assign w_p    = A ^ B;
  assign w_c[0] = C0;
  assign w_c[1] = w_g[0]
                | (w_p[0] & C0);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & C0);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & C0);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & C0);

  assign S  = w_p ^ w_c[3:0];
  assign C4 = w_c[4];
  assign C3 = w_c[3];
endmodule

// File: rtl/serial_adder32.sv
// Nibble-serial add/subtract: one 4-bit CLA slice reused
// for WIDTH/4 cycles, valid/ready on both sides.
module serial_adder32
  import serial_adder32_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           r_state;
  state_e           w_nstate;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_an;
  logic [3:0]       w_bn;
  logic [3:0]       w_s;
  logic             w_c4;
  logic             w_c3;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nx;

  assign w_an   = r_a[4*r_k +: 4];
  assign w_bn   = r_b[4*r_k +: 4];
  assign w_last = (r_k == KW'(NIB - 1));

  Adder4 u_add (
    .A  (w_an),
    .B  (w_bn),
    .C0 (r_cin),
    .S  (w_s),
    .C4 (w_c4),
    .C3 (w_c3)
  );

  // Sum with the current nibble merged in, so zero sees the final value
  always_comb begin
    w_sum_nx = r_sum;
    w_sum_nx[4*r_k +: 4] = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_nstate = S_RUN;
      S_RUN:   if (w_last)    w_nstate = S_DONE;
      S_DONE:  if (out_ready) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_cin <= sub;
            r_k   <= '0;
          end
        end
        S_RUN: begin
          r_sum <= w_sum_nx;
          r_cin <= w_c4;
          if (w_last) begin
            r_carry <= w_c4;
            r_ovf   <= w_c4 ^ w_c3;
            r_zero  <= (w_sum_nx == '0);
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_serial_adder32.sv
// Scoreboard bench for serial_adder32: directed vectors,
// backpressure hold, mid-run reset and random back-to-back ops.
module tb_serial_adder32;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry;
  logic        overflow;
  logic        zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t sb[$];

  serial_adder32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        s
  );
    exp_t        e;
    logic [32:0] t;
    if (s) t = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else   t = {1'b0, x} + {1'b0, y};
    e.s = t[31:0];
    e.c = t[32];
    if (s) e.v = (x[31] != y[31]) && (e.s[31] != x[31]);
    else   e.v = (x[31] == y[31]) && (e.s[31] != x[31]);
    e.z = (e.s == 32'd0);
    return e;
  endfunction

  task automatic start_op(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        s,
    input bit          push
  );
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready got=%b want=1", in_ready);
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    @(posedge clk);
    if (push) sb.push_back(model(x, y, s));
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom);
  endtask

  task automatic finish_op(input int hold);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL out_valid_timeout got=0 want=1");
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL latency got=%0d want=8", lat);
    end
    total++;
    if (sum !== e.s) begin
      bad++;
      $display("FAIL sum got=%h want=%h", sum, e.s);
    end
    total++;
    if (carry !== e.c) begin
      bad++;
      $display("FAIL carry got=%b want=%b", carry, e.c);
    end
    total++;
    if (overflow !== e.v) begin
      bad++;
      $display("FAIL overflow got=%b want=%b", overflow, e.v);
    end
    total++;
    if (zero !== e.z) begin
      bad++;
      $display("FAIL zero got=%b want=%b", zero, e.z);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sum !== e.s || carry !== e.c ||
          overflow !== e.v || zero !== e.z) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%b%b %h %b%b%b want=10 %h %b%b%b",
                 h, out_valid, in_ready, sum, carry, overflow, zero,
                 e.s, e.c, e.v, e.z);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== e.s ||
        carry !== e.c || overflow !== e.v || zero !== e.z) begin
      bad++;
      $display("FAIL release got=%b%b %h %b%b%b want=10 %h %b%b%b",
               in_ready, out_valid, sum, carry, overflow, zero,
               e.s, e.c, e.v, e.z);
    end
  endtask

  task automatic run_op(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        s,
    input int          hold
  );
    start_op(x, y, s, 1'b1);
    finish_op(hold);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'd0 ||
        carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL reset got=%b%b %h %b%b%b want=10 0 000",
               in_ready, out_valid, sum, carry, overflow, zero);
    end
  endtask

  task automatic test_vectors;
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h0000_0007, 32'h0000_0007, 1'b1, 0);
  endtask

  task automatic test_hold;
    run_op(32'h1234_5678, 32'h8765_4321, 1'b0, 5);
  endtask

  task automatic test_abort;
    bit seen;
    start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'd0 ||
        carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL abort_state got=%b%b %h %b%b%b want=10 0 000",
               in_ready, out_valid, sum, carry, overflow, zero);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_quiet got=active want=idle");
    end
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, 1'($urandom),
             int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_abort();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder32.md
SERIAL_ADDER32 -- requirements
Module: serial_adder32

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; a multiple of 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operands and op presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port: a  input  WIDTH  first operand.
REQ-007 SHALL have port: b  input  WIDTH  second operand.
REQ-008 SHALL have port: sub  input  1  0 = a+b; 1 = a-b.
REQ-009 SHALL have port: out_valid  output  1  result and flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: sum  output  WIDTH  result.
REQ-012 SHALL have port: carry  output  1  carry-out of the MSB nibble (for sub, 1 = no borrow).
REQ-013 SHALL have port: overflow  output  1  signed overflow.
REQ-014 SHALL have port: zero  output  1  sum equals 0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), combinational.
REQ-016 In IDLE, in_valid&in_ready SHALL latch a, (sub ? ~b : b), carry register = sub, nibble index k = 0, and move to RUN.
REQ-017 In RUN, each cycle SHALL add nibble k of the latched operands plus the carry register in one 4-bit carry-lookahead slice, write S into sum bits [4k+3:4k], load carry register with C4, and increment k.
REQ-018 On the last nibble (k = WIDTH/4-1), the block SHALL set carry = C4, overflow = C4 XOR C3, and move to DONE; k SHALL NOT wrap past WIDTH/4-1.
REQ-019 zero SHALL be registered on entry to DONE and equal (final sum == 0).
REQ-020 out_valid SHALL be 1 only in DONE; sum and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1, the block SHALL return to IDLE next cycle; no same-cycle accept (in_ready stays 0 in DONE).
REQ-022 Latency: accept at edge T -> out_valid high after edge T+WIDTH/4 (T+8 for WIDTH=32); throughput one op per WIDTH/4+2 cycles minimum.
REQ-023 in_valid, a, b, sub SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-024 sum and flags SHALL retain the last completed result in IDLE until overwritten during the next RUN.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, k=0, carry register=0, sum=0, carry=0, overflow=0, zero=0, out_valid=0.
REQ-026 rst asserted in RUN or DONE SHALL abandon the operation with no out_valid pulse; reset SHALL take priority over every other event.

Structure
REQ-027 A shared package SHALL hold the WIDTH default, NIBBLES = WIDTH/4, and the FSM state encoding.
REQ-028 The block SHALL instantiate exactly one existing 4-bit carry-lookahead adder (Adder4: A, B, C0, S, C4, C3) as its sole sub-module; no other arithmetic on the datapath.

Verification
REQ-029 a=0x00000001, b=0x00000001, sub=0 -> after 8 RUN cycles sum=0x00000002, carry=0, overflow=0, zero=0.
REQ-030 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, carry=1, overflow=0, zero=1.
REQ-031 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, carry=0, overflow=1; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1, carry=1.
REQ-032 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, carry=0, overflow=0; a=7, b=7, sub=1 -> sum=0, carry=1, zero=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, flags unchanged and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 Assert rst for 1 cycle at RUN k=3 -> next cycle IDLE, all outputs 0, no out_valid; a fresh op then completes with correct result.
